// File: rtl/pwm_dac.sv
`default_nettype none
// ============================================================================
// Module      : pwm_dac
// Description : Converts magnitude samples into a period-aligned PWM output
//               with valid/ready sample intake and a graceful-stop FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_dac #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] magnitude,
    input  logic             mag_valid,
    output logic             mag_ready,
    output logic             pwm_out,
    output logic             period_start,
    output logic             busy
);

    localparam int                PW           = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]     c_presc_last = PW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0]  c_cnt_last   = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [PW-1:0]    r_presc;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_duty;
    logic [WIDTH-1:0] r_shadow;
    logic             r_shadow_full;
    logic             r_pwm;
    logic             r_period_start;

    logic             w_tick;
    logic             w_boundary;
    logic             w_accept;
    logic             w_load;

    assign w_tick     = (r_state != S_IDLE) && (r_presc == c_presc_last);
    assign w_boundary = w_tick && (r_cnt == c_cnt_last);
    assign w_accept   = mag_valid && !r_shadow_full;

    // Duty reloads only on start from IDLE or on a boundary while running;
    // re-entering RUN from DRAIN keeps the current period untouched.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (en) begin
                    w_state_next = S_RUN;
                    w_load       = 1'b1;
                end
            end
            S_RUN: begin
                if (!en) begin
                    w_state_next = S_DRAIN;
                end else if (w_boundary) begin
                    w_load = 1'b1;
                end
            end
            S_DRAIN: begin
                if (en) begin
                    w_state_next = S_RUN;
                end else if (w_boundary) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_presc        <= '0;
            r_cnt          <= '0;
            r_duty         <= '0;
            r_shadow       <= '0;
            r_shadow_full  <= 1'b0;
            r_pwm          <= 1'b0;
            r_period_start <= 1'b0;
        end else begin
            r_state <= w_state_next;

            // In IDLE the counters sit at zero so a start always begins at cnt 0.
            if (r_state == S_IDLE) begin
                r_presc <= '0;
                r_cnt   <= '0;
            end else if (w_tick) begin
                r_presc <= '0;
                r_cnt   <= r_cnt + 1'b1;
            end else begin
                r_presc <= r_presc + 1'b1;
            end

            r_period_start <= w_load;
            if (w_load && r_shadow_full) begin
                r_duty <= r_shadow;
            end

            // Accept and load-from-full are mutually exclusive on shadow_full.
            if (w_load && r_shadow_full) begin
                r_shadow_full <= 1'b0;
            end else if (w_accept) begin
                r_shadow_full <= 1'b1;
            end
            if (w_accept) begin
                r_shadow <= magnitude;
            end

            r_pwm <= (r_state != S_IDLE) && (r_cnt < r_duty);
        end
    end

    assign mag_ready    = !r_shadow_full;
    assign pwm_out      = r_pwm;
    assign period_start = r_period_start;
    assign busy         = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_pwm_dac.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_dac
// Description : Self-checking bench for pwm_dac (PRESCALE 1 and 4 instances).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_dac;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       en1, valid1, ready1, pwm1, ps1, busy1;
    logic [7:0] mag1;
    logic       en4, valid4, ready4, pwm4, ps4, busy4;
    logic [7:0] mag4;

    int n_tests = 0;
    int n_fail  = 0;

    pwm_dac #(.WIDTH(8), .PRESCALE(1)) dut1 (
        .clk(clk), .rst(rst), .en(en1), .magnitude(mag1), .mag_valid(valid1),
        .mag_ready(ready1), .pwm_out(pwm1), .period_start(ps1), .busy(busy1)
    );

    pwm_dac #(.WIDTH(8), .PRESCALE(4)) dut4 (
        .clk(clk), .rst(rst), .en(en4), .magnitude(mag4), .mag_valid(valid4),
        .mag_ready(ready4), .pwm_out(pwm4), .period_start(ps4), .busy(busy4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: within a 256-tick period, output is high for ticks below duty.
    function automatic logic [255:0] duty_pattern(input logic [7:0] m);
        logic [255:0] v;
        for (int i = 0; i < 256; i++) v[i] = (i < int'(m));
        return v;
    endfunction

    function automatic logic [255:0] start_pattern();
        logic [255:0] v;
        v      = '0;
        v[255] = 1'b1;
        return v;
    endfunction

    // Push a sample into an empty shadow, then start from IDLE.
    task automatic start_run(input logic [7:0] m);
        valid1 = 1'b1;
        mag1   = m;
        tick();
        n_tests++;
        if (ready1 !== 1'b0) begin
            n_fail++;
            $display("FAIL push_ready: got %0b expected 0", ready1);
        end
        valid1 = 1'b0;
        en1    = 1'b1;
        tick();
        n_tests += 2;
        if (ps1 !== 1'b1) begin
            n_fail++;
            $display("FAIL first_period_start: got %0b expected 1", ps1);
        end
        if (busy1 !== 1'b1) begin
            n_fail++;
            $display("FAIL start_busy: got %0b expected 1", busy1);
        end
    endtask

    task automatic run_periods(input logic [7:0] m, input int nper, input string name);
        logic [255:0] got_pwm, got_ps;
        for (int p = 0; p < nper; p++) begin
            for (int i = 0; i < 256; i++) begin
                tick();
                got_pwm[i] = pwm1;
                got_ps[i]  = ps1;
            end
            n_tests += 2;
            if (got_pwm !== duty_pattern(m)) begin
                n_fail++;
                $display("FAIL %s_pwm period %0d: got %h expected %h", name, p, got_pwm, duty_pattern(m));
            end
            if (got_ps !== start_pattern()) begin
                n_fail++;
                $display("FAIL %s_period_start period %0d: got %h expected %h", name, p, got_ps, start_pattern());
            end
        end
    endtask

    task automatic stop_wait();
        int cycles;
        en1    = 1'b0;
        cycles = 0;
        while (busy1 === 1'b1 && cycles < 600) begin
            tick();
            cycles++;
        end
        n_tests++;
        if (busy1 !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_timeout: busy got %0b expected 0 after %0d cycles", busy1, cycles);
        end
        tick();
    endtask

    task automatic test_reset();
        int bad;
        rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            en1 = 1'($urandom); valid1 = 1'($urandom); mag1 = 8'($urandom);
            tick();
        end
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            en1 = 1'($urandom); valid1 = 1'($urandom); mag1 = 8'($urandom);
            tick();
        end
        n_tests += 4;
        if (pwm1 !== 1'b0)   begin n_fail++; $display("FAIL reset_pwm: got %0b expected 0", pwm1); end
        if (ps1 !== 1'b0)    begin n_fail++; $display("FAIL reset_period_start: got %0b expected 0", ps1); end
        if (busy1 !== 1'b0)  begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", busy1); end
        if (ready1 !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b expected 1", ready1); end
        rst = 1'b0; en1 = 1'b0; valid1 = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (pwm1 !== 1'b0 || ps1 !== 1'b0 || busy1 !== 1'b0) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL reset_quiet: got %0d active cycles expected 0", bad);
        end
    endtask

    task automatic test_main_duty();
        start_run(8'd64);
        run_periods(8'd64, 4, "duty64");
        stop_wait();
    endtask

    task automatic test_edge_duties();
        start_run(8'd0);
        run_periods(8'd0, 2, "duty0");
        stop_wait();
        start_run(8'd255);
        run_periods(8'd255, 2, "duty255");
        stop_wait();
    endtask

    task automatic test_random_duties();
        logic [7:0] m;
        for (int r = 0; r < 3; r++) begin
            m = 8'($urandom_range(1, 254));
            start_run(m);
            run_periods(m, 2, "rand");
            stop_wait();
        end
    endtask

    task automatic test_mid_update();
        logic [255:0] got_pwm [3];
        logic [255:0] got_ps  [3];
        logic [7:0]   exp_m   [3];
        int           rdy_bad;
        logic         rdy_before, rdy_after;
        exp_m[0] = 8'd64; exp_m[1] = 8'd192; exp_m[2] = 8'd192;
        rdy_bad = 0; rdy_before = 1'b0; rdy_after = 1'b0;
        start_run(8'd64);
        for (int k = 1; k <= 768; k++) begin
            if (k == 101) begin
                valid1 = 1'b1; mag1 = 8'd192;
            end else if (k >= 102 && k <= 256) begin
                valid1 = 1'b1; mag1 = 8'd77;
            end else begin
                valid1 = 1'b0;
            end
            tick();
            got_pwm[(k-1)/256][(k-1)%256] = pwm1;
            got_ps[(k-1)/256][(k-1)%256]  = ps1;
            if (k == 100) rdy_before = ready1;
            if (k >= 101 && k <= 255 && ready1 !== 1'b0) rdy_bad++;
            if (k == 256) rdy_after = ready1;
        end
        n_tests += 3;
        if (rdy_before !== 1'b1) begin n_fail++; $display("FAIL mid_ready_before: got %0b expected 1", rdy_before); end
        if (rdy_bad != 0) begin n_fail++; $display("FAIL mid_ready_held: got %0d ready cycles expected 0", rdy_bad); end
        if (rdy_after !== 1'b1) begin n_fail++; $display("FAIL mid_ready_after: got %0b expected 1", rdy_after); end
        for (int p = 0; p < 3; p++) begin
            n_tests += 2;
            if (got_pwm[p] !== duty_pattern(exp_m[p])) begin
                n_fail++;
                $display("FAIL mid_pwm period %0d: got %h expected %h", p, got_pwm[p], duty_pattern(exp_m[p]));
            end
            if (got_ps[p] !== start_pattern()) begin
                n_fail++;
                $display("FAIL mid_period_start period %0d: got %h expected %h", p, got_ps[p], start_pattern());
            end
        end
        stop_wait();
    endtask

    task automatic test_graceful_stop();
        logic [255:0] got_pwm [2];
        logic [255:0] got_ps  [2];
        logic [7:0]   m, m2, m3;
        int           busy_bad, ps_bad, pwm_bad;
        // Drop en at cnt 100 and let the period drain.
        m = 8'($urandom_range(1, 254));
        busy_bad = 0; ps_bad = 0; pwm_bad = 0;
        start_run(m);
        for (int k = 1; k <= 260; k++) begin
            en1 = (k <= 100);
            tick();
            if (k <= 256) got_pwm[0][k-1] = pwm1;
            else if (pwm1 !== 1'b0) pwm_bad++;
            if (busy1 !== (k <= 255)) busy_bad++;
            if (ps1 !== 1'b0) ps_bad++;
        end
        n_tests += 4;
        if (got_pwm[0] !== duty_pattern(m)) begin
            n_fail++; $display("FAIL drain_pwm: got %h expected %h", got_pwm[0], duty_pattern(m));
        end
        if (busy_bad != 0) begin n_fail++; $display("FAIL drain_busy: got %0d bad cycles expected 0", busy_bad); end
        if (ps_bad != 0)   begin n_fail++; $display("FAIL drain_period_start: got %0d pulses expected 0", ps_bad); end
        if (pwm_bad != 0)  begin n_fail++; $display("FAIL drain_idle_pwm: got %0d high cycles expected 0", pwm_bad); end

        // Drop en at cnt 100, reassert at cnt 200, new sample pushed while draining.
        m2 = 8'($urandom_range(1, 254));
        m3 = 8'($urandom_range(1, 254));
        if (m3 == m2) m3 = m2 ^ 8'h80;
        busy_bad = 0;
        start_run(m2);
        for (int k = 1; k <= 512; k++) begin
            en1    = !(k >= 101 && k <= 200);
            valid1 = (k == 150);
            mag1   = m3;
            tick();
            got_pwm[(k-1)/256][(k-1)%256] = pwm1;
            got_ps[(k-1)/256][(k-1)%256]  = ps1;
            if (busy1 !== 1'b1) busy_bad++;
        end
        valid1 = 1'b0;
        n_tests += 5;
        if (busy_bad != 0) begin n_fail++; $display("FAIL resume_busy: got %0d idle cycles expected 0", busy_bad); end
        if (got_pwm[0] !== duty_pattern(m2)) begin
            n_fail++; $display("FAIL resume_pwm0: got %h expected %h", got_pwm[0], duty_pattern(m2));
        end
        if (got_pwm[1] !== duty_pattern(m3)) begin
            n_fail++; $display("FAIL resume_pwm1: got %h expected %h", got_pwm[1], duty_pattern(m3));
        end
        if (got_ps[0] !== start_pattern()) begin
            n_fail++; $display("FAIL resume_ps0: got %h expected %h", got_ps[0], start_pattern());
        end
        if (got_ps[1] !== start_pattern()) begin
            n_fail++; $display("FAIL resume_ps1: got %h expected %h", got_ps[1], start_pattern());
        end
        stop_wait();
    endtask

    task automatic test_prescale4();
        int highs, first_hi, last_hi, ps_cnt, ps_at, cycles;
        valid4 = 1'b1; mag4 = 8'd10;
        tick();
        valid4 = 1'b0; en4 = 1'b1;
        tick();
        n_tests++;
        if (ps4 !== 1'b1) begin n_fail++; $display("FAIL p4_first_period_start: got %0b expected 1", ps4); end
        highs = 0; first_hi = -1; last_hi = -1; ps_cnt = 0; ps_at = -1;
        for (int k = 1; k <= 1024; k++) begin
            tick();
            if (pwm4 === 1'b1) begin
                highs++;
                if (first_hi < 0) first_hi = k;
                last_hi = k;
            end
            if (ps4 === 1'b1) begin ps_cnt++; ps_at = k; end
        end
        n_tests += 4;
        if (highs != 40)    begin n_fail++; $display("FAIL p4_high_count: got %0d expected 40", highs); end
        if (first_hi != 1 || last_hi != 40) begin
            n_fail++; $display("FAIL p4_high_span: got %0d..%0d expected 1..40", first_hi, last_hi);
        end
        if (ps_cnt != 1)    begin n_fail++; $display("FAIL p4_ps_count: got %0d expected 1", ps_cnt); end
        if (ps_at != 1024)  begin n_fail++; $display("FAIL p4_ps_position: got %0d expected 1024", ps_at); end

        // Pending sample pushed, then reset at cnt 50 of the second period.
        highs = 0;
        for (int k = 1; k <= 200; k++) begin
            valid4 = (k == 10); mag4 = 8'd99;
            tick();
            if (pwm4 === 1'b1) highs++;
        end
        valid4 = 1'b0;
        n_tests++;
        if (highs != 40) begin n_fail++; $display("FAIL p4_repeat_high_count: got %0d expected 40", highs); end
        rst = 1'b1;
        tick();
        n_tests += 4;
        if (pwm4 !== 1'b0)   begin n_fail++; $display("FAIL p4_rst_pwm: got %0b expected 0", pwm4); end
        if (busy4 !== 1'b0)  begin n_fail++; $display("FAIL p4_rst_busy: got %0b expected 0", busy4); end
        if (ready4 !== 1'b1) begin n_fail++; $display("FAIL p4_rst_ready: got %0b expected 1", ready4); end
        if (ps4 !== 1'b0)    begin n_fail++; $display("FAIL p4_rst_ps: got %0b expected 0", ps4); end
        rst = 1'b0; en4 = 1'b0;
        tick();
        en4 = 1'b1;
        tick();
        n_tests++;
        if (ps4 !== 1'b1) begin n_fail++; $display("FAIL p4_restart_ps: got %0b expected 1", ps4); end
        highs = 0;
        for (int k = 1; k <= 1024; k++) begin
            tick();
            if (pwm4 === 1'b1) highs++;
        end
        n_tests++;
        if (highs != 0) begin n_fail++; $display("FAIL p4_shadow_cleared: got %0d high cycles expected 0", highs); end
        en4 = 1'b0;
        cycles = 0;
        while (busy4 === 1'b1 && cycles < 2000) begin
            tick();
            cycles++;
        end
        n_tests++;
        if (busy4 !== 1'b0) begin n_fail++; $display("FAIL p4_stop_timeout: busy got %0b expected 0", busy4); end
    endtask

    initial begin
        rst = 1'b1;
        en1 = 1'b0; valid1 = 1'b0; mag1 = '0;
        en4 = 1'b0; valid4 = 1'b0; mag4 = '0;
        repeat (3) tick();
        test_reset();
        test_main_duty();
        test_edge_duties();
        test_random_duties();
        test_mid_update();
        test_graceful_stop();
        test_prescale4();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
